// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC types and constants for the credit relay slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_WIDTH_DEFAULT = 128;
    localparam int DEST_WIDTH_DEFAULT = 4;
    localparam int STATS_WIDTH        = 32;

    // One buffered flit: payload, routing field and packet-end marker.
    typedef struct packed {
        logic [FLIT_WIDTH_DEFAULT-1:0] data;
        logic [DEST_WIDTH_DEFAULT-1:0] dest;
        logic                          is_tail;
    } flit_t;

endpackage

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : noc_flit_fifo
//  Description : Register-array flit FIFO with combinational head read.
//                A push on a full FIFO is accepted only when a pop frees the
//                head slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = $bits(flit_t),
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/noc_credit_relay.sv
`default_nettype none
// ============================================================================
//  Module      : noc_credit_relay
//  Description : Credit-terminating relay station for a router-to-router
//                link. Upstream credits are returned as flits leave the local
//                FIFO; downstream sends are governed by a local counter that
//                mirrors the next router's input buffer.
//                Optional statistics: define NOC_CREDIT_RELAY_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_credit_relay
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH         = 128,
    parameter int DEST_WIDTH         = 4,
    parameter int BUFFER_DEPTH       = 2,
    parameter int DOWNSTREAM_CREDITS = 2,
    parameter int CREDIT_WIDTH       = $clog2(DOWNSTREAM_CREDITS + 1)
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    output logic                   overflow_err,
    output logic                   credit_err,
    output logic [STATS_WIDTH-1:0] flit_count,
    output logic [STATS_WIDTH-1:0] stall_cycles
);

    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int FCNT_W  = $clog2(BUFFER_DEPTH + 1);
    localparam logic [CREDIT_WIDTH-1:0] c_credits_max = CREDIT_WIDTH'(DOWNSTREAM_CREDITS);

    logic [ENTRY_W-1:0]      w_wr_entry;
    logic [ENTRY_W-1:0]      w_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_credit_sat;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic [CREDIT_WIDTH-1:0] w_credits_nxt;

    assign w_wr_entry = {data_in, dest_in, is_tail_in};

    // Forward a flit whenever one is buffered and the downstream has room.
    assign w_pop  = !fifo_empty && (r_credits != '0);
    // A full FIFO with no simultaneous pop cannot take the incoming flit.
    assign w_drop = send_in && fifo_full && !w_pop;
    // Credit returned while the counter is already at its ceiling.
    assign w_credit_sat = credit_in && !w_pop && (r_credits == c_credits_max);

    noc_flit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUFFER_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk     (clk_noc),
        .rst     (rst_noc),
        .push    (send_in),
        .wr_data (w_wr_entry),
        .pop     (w_pop),
        .head    (w_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next downstream credit count: pop consumes, credit_in returns, saturating.
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_pop && !credit_in)
            w_credits_nxt = r_credits - 1'b1;
        else if (credit_in && !w_pop && (r_credits != c_credits_max))
            w_credits_nxt = r_credits + 1'b1;
    end

    // Credit counter, registered output stage and sticky error flags.
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            r_credits    <= c_credits_max;
            send_out     <= 1'b0;
            credit_out   <= 1'b0;
            data_out     <= '0;
            dest_out     <= '0;
            is_tail_out  <= 1'b0;
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            r_credits  <= w_credits_nxt;
            send_out   <= w_pop;
            credit_out <= w_pop;
            if (w_pop) begin
                {data_out, dest_out, is_tail_out} <= w_head;
            end
            if (w_drop)       overflow_err <= 1'b1;
            if (w_credit_sat) credit_err   <= 1'b1;
        end
    end

`ifdef NOC_CREDIT_RELAY_STATS_EN
    // Forwarded-flit and credit-starvation counters, wrapping at 2^32.
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            flit_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (w_pop) flit_count <= flit_count + 1'b1;
            if ((fifo_count != '0) && (r_credits == '0))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign flit_count   = '0;
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_credit_relay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_credit_relay
//  Description : Self-checking bench for noc_credit_relay: a queue-based
//                reference model compared every cycle, plus directed
//                literal expectations per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_credit_relay;

    localparam int FW = 128;
    localparam int DW = 4;
    localparam int BD = 2;
    localparam int DC = 2;

    logic          clk_noc    = 1'b0;
    logic          rst_noc    = 1'b1;
    logic [FW-1:0] data_in    = '0;
    logic [DW-1:0] dest_in    = '0;
    logic          is_tail_in = 1'b0;
    logic          send_in    = 1'b0;
    logic          credit_in  = 1'b0;
    logic          credit_out;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          overflow_err;
    logic          credit_err;
    logic [31:0]   flit_count;
    logic [31:0]   stall_cycles;

    always #5 clk_noc = ~clk_noc;

    noc_credit_relay #(
        .FLIT_WIDTH         (FW),
        .DEST_WIDTH         (DW),
        .BUFFER_DEPTH       (BD),
        .DOWNSTREAM_CREDITS (DC)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc      (rst_noc),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .data_out     (data_out),
        .dest_out     (dest_out),
        .is_tail_out  (is_tail_out),
        .send_out     (send_out),
        .credit_in    (credit_in),
        .overflow_err (overflow_err),
        .credit_err   (credit_err),
        .flit_count   (flit_count),
        .stall_cycles (stall_cycles)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [FW-1:0] d;
        logic [DW-1:0] t;
        logic          tl;
    } fl_t;

    fl_t           mq[$];
    fl_t           m_head;
    int            m_cred;
    int            m_sz;
    bit            m_pop;
    bit            m_live = 1'b0;
    logic          e_send, e_tail, e_ovf, e_cerr;
    logic [FW-1:0] e_data;
    logic [DW-1:0] e_dest;
    logic [31:0]   m_flits, m_stalls;

    // At each falling edge: check the previous edge's outputs, then predict
    // what the coming rising edge will produce from the now-stable inputs.
    always @(negedge clk_noc) begin
        if (m_live) begin
            chk("send_out",     send_out,     e_send);
            chk("credit_out",   credit_out,   e_send);
            chk("data_out",     data_out,     e_data);
            chk("dest_out",     dest_out,     e_dest);
            chk("is_tail_out",  is_tail_out,  e_tail);
            chk("overflow_err", overflow_err, e_ovf);
            chk("credit_err",   credit_err,   e_cerr);
`ifdef NOC_CREDIT_RELAY_STATS_EN
            chk("flit_count",   flit_count,   m_flits);
            chk("stall_cycles", stall_cycles, m_stalls);
`else
            chk("flit_count",   flit_count,   32'd0);
            chk("stall_cycles", stall_cycles, 32'd0);
`endif
        end
        if (rst_noc) begin
            mq.delete();
            m_cred   = DC;
            e_send   = 1'b0;
            e_data   = '0;
            e_dest   = '0;
            e_tail   = 1'b0;
            e_ovf    = 1'b0;
            e_cerr   = 1'b0;
            m_flits  = '0;
            m_stalls = '0;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && (m_cred > 0);
            if (m_sz > 0 && m_cred == 0) m_stalls = m_stalls + 1;
            e_send = m_pop;
            if (m_pop) begin
                m_head  = mq.pop_front();
                e_data  = m_head.d;
                e_dest  = m_head.t;
                e_tail  = m_head.tl;
                m_flits = m_flits + 1;
            end
            if (send_in) begin
                if (m_sz == BD && !m_pop) e_ovf = 1'b1;
                else mq.push_back({data_in, dest_in, is_tail_in});
            end
            if (m_pop && !credit_in) m_cred--;
            else if (credit_in && !m_pop) begin
                if (m_cred == DC) e_cerr = 1'b1;
                else m_cred++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk_noc);
        #1;
    endtask

    task automatic do_reset;
        rst_noc = 1'b1;
        send_in = 1'b0;
        credit_in = 1'b0;
        tick();
        rst_noc = 1'b0;
    endtask

    task automatic drive(input logic s, input logic [FW-1:0] d, input logic [DW-1:0] t, input logic tl);
        send_in = s;
        data_in = d;
        dest_in = t;
        is_tail_in = tl;
    endtask

    int n_sent;
    int run;
    int best_run;

    initial begin
        rst_noc = 1'b1;
        tick();
        tick();
        rst_noc = 1'b0;
        chk("reset send_out",   send_out,   1'b0);
        chk("reset credit_out", credit_out, 1'b0);
        chk("reset data_out",   data_out,   128'h0);
        chk("reset errors",     {overflow_err, credit_err}, 2'b00);

        // Single flit: visible two edges later, for one cycle only.
        drive(1'b1, 128'hA5, 4'h3, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("single c1 send_out", send_out, 1'b0);
        tick();
        chk("single c2 send_out",   send_out,    1'b1);
        chk("single c2 credit_out", credit_out,  1'b1);
        chk("single c2 data",       data_out,    128'hA5);
        chk("single c2 dest",       dest_out,    4'h3);
        chk("single c2 tail",       is_tail_out, 1'b1);
        tick();
        chk("single c3 send_out", send_out, 1'b0);
        chk("single c3 data hold", data_out, 128'hA5);
        tick();
        tick();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        tick();

        // Four back-to-back flits with two downstream credits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 128'h100 + i, 4'(i), i == 3);
            tick();
            if (i == 1) chk("b2b c2 data", {send_out, data_out}, {1'b1, 128'h100});
            if (i == 2) chk("b2b c3 data", {send_out, data_out}, {1'b1, 128'h101});
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("b2b c4 send_out", send_out, 1'b0);
        tick();
        tick();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("b2b c7 send_out", send_out, 1'b0);
        tick();
        chk("b2b c8 third flit", {send_out, data_out, dest_out}, {1'b1, 128'h102, 4'h2});
        tick();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        chk("b2b fourth flit", {send_out, data_out, is_tail_out}, {1'b1, 128'h103, 1'b1});
        chk("b2b no overflow", overflow_err, 1'b0);
        tick();

        // Overflow: counter exhausted, third queued flit is dropped.
        do_reset();
        drive(1'b1, 128'h200, 4'h0, 1'b0); tick();
        drive(1'b1, 128'h201, 4'h1, 1'b0); tick();
        drive(1'b1, 128'h210, 4'h4, 1'b0); tick();
        drive(1'b1, 128'h211, 4'h5, 1'b0); tick();
        drive(1'b1, 128'h212, 4'h6, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("ovf set", overflow_err, 1'b1);
        tick();
        chk("ovf held", overflow_err, 1'b1);
        credit_in = 1'b1; tick();
        tick();
        credit_in = 1'b0;
        chk("ovf first delivered", {send_out, data_out}, {1'b1, 128'h210});
        tick();
        chk("ovf second delivered", {send_out, data_out}, {1'b1, 128'h211});
        tick();
        chk("ovf nothing more", send_out, 1'b0);
        chk("ovf still held", overflow_err, 1'b1);

        // Credit returned with the counter already full.
        do_reset();
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("cerr set", credit_err, 1'b1);
        drive(1'b1, 128'h5A, 4'h9, 1'b0); tick();
        drive(1'b1, 128'h5B, 4'hA, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("cerr held", credit_err, 1'b1);
        tick();
        tick();
        tick();

        // Streaming with credits echoed back one cycle after each send.
        do_reset();
        n_sent = 0; run = 0; best_run = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) drive(1'b1, 128'h300 + i, 4'(i), i == 7);
            else       drive(1'b0, '0, '0, 1'b0);
            credit_in = send_out;
            tick();
            if (send_out) begin
                n_sent++;
                run++;
                if (run > best_run) best_run = run;
            end else begin
                run = 0;
            end
        end
        credit_in = 1'b0;
        chk("stream flits", n_sent, 8);
        chk("stream 1/cycle", best_run, 8);
        chk("stream no errors", {overflow_err, credit_err}, 2'b00);
`ifdef NOC_CREDIT_RELAY_STATS_EN
        chk("stream flit_count", flit_count, 32'd8);
`endif

        // Reset mid-transfer with buffered flits, no credits and an error set.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 128'h400 + i, 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("mid ovf before reset", overflow_err, 1'b1);
        do_reset();
        chk("mid rst outputs", {send_out, credit_out, data_out, dest_out, is_tail_out},
            {1'b0, 1'b0, 128'h0, 4'h0, 1'b0});
        chk("mid rst errors", {overflow_err, credit_err}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid no spurious send", send_out, 1'b0);
        end
        drive(1'b1, 128'h500, 4'h1, 1'b0); tick();
        drive(1'b1, 128'h501, 4'h2, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("mid post-reset first", {send_out, data_out}, {1'b1, 128'h500});
        tick();
        chk("mid post-reset second", {send_out, data_out}, {1'b1, 128'h501});
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
